ltc_decoder: RTL and testbench
==============================

# ltc_decoder

Receives a serial SMPTE-style linear timecode (LTC) bitstream, biphase-mark encoded, and recovers the 80-bit frame. It searches for the sync word, extracts the BCD time fields, and presents them with a one-cycle valid strobe. It is the receive end of the timecode encoder path and sits between an external LTC input pin and the time-of-day logic. Bit timing is derived by measuring the interval between line transitions, so no recovered clock is needed.

## Interface
- `SHORT_MAX`, default 8437: max interval in clk cycles still classed as a half-bit; larger intervals are full bits. Intended value is 0.75 × bit period.
- `TIMEOUT`, default 22500: number of clk cycles with no transition after which lock is lost.
- `CNT_W`, default 16: interval counter width; must hold `TIMEOUT`.
- `clk`  in  1  single system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ltc_in`  in  1  raw LTC line; asynchronous to `clk`.
- `hours`  out  6  BCD {tens[1:0], units[3:0]}.
- `minutes`  out  7  BCD {tens[2:0], units[3:0]}.
- `seconds`  out  7  BCD {tens[2:0], units[3:0]}.
- `frames`  out  6  BCD {tens[1:0], units[3:0]}.
- `drop_frame`  out  1  frame bit 10.
- `frame_valid`  out  1  one-cycle pulse; all field outputs updated in the same cycle.
- `locked`  out  1  high after the first valid frame, until any loss-of-lock event.
- `bcd_err`  out  1  one-cycle pulse when a frame is rejected; see Configuration.

## Operation
- **Input synchronisation:** `ltc_in` passes through two flops (s1, s2), and s3 holds the previous s2. A transition is detected when `edge = s2 ^ s3`.
- **Interval counter:** counts cycles since the last edge, clears to 0 on each edge, and saturates at `TIMEOUT`.
- **Edge classification:**
  - Short interval (≤ `SHORT_MAX`):
    - if `half_pending` is 0, set it;
    - otherwise emit bit 1 and clear it.
  - Long interval:
    - if `half_pending` is 0, emit bit 0;
    - otherwise this is a phase error: clear `half_pending`, emit nothing, and clear `locked` and `bit_cnt`.
- **Timeout:** when the counter reaches `TIMEOUT`, clear `locked`, `half_pending` and `bit_cnt`. The first edge after a timeout only restarts timing and emits no bit.
- **Shift register:** an emitted bit b loads `sr <= {b, sr[79:1]}`, giving LSB-first assembly so that `sr[0]` is frame bit 0.
- **Bit counter:** `bit_cnt` counts bits since reset, timeout or the last sync match, and saturates at 81.
- **Sync detection:** sync is matched when the next-state `sr[79:64] == 16'hBFFC` (frame bits 64..79 = 0011111111111101 in transmission order).
  - If matched and the bit count including this bit is exactly 80: the frame is accepted, subject to Configuration. `frame_valid` pulses, outputs load, `locked` is set, and `bit_cnt` is cleared.
  - If matched with any other count: misaligned. No strobe; clear `locked` and `bit_cnt`.
  - If `bit_cnt` reaches 81 without a sync match: clear `locked`.
- **Field map:**
  - frames = {sr[9:8], sr[3:0]}
  - drop_frame = sr[10]
  - seconds = {sr[26:24], sr[19:16]}
  - minutes = {sr[42:40], sr[35:32]}
  - hours = {sr[57:56], sr[51:48]}
- User bits are ignored.
- Field outputs hold the last accepted frame until the next accepted frame.

## Timing
- Reset values: all outputs 0, plus `sr`, counters, `half_pending` and the sync flops.
- Latency: a transition on `ltc_in` before posedge 1 gives edge = 1 after posedge 2. The bit is processed at posedge 3, so `frame_valid` and new fields are visible after posedge 3, i.e. 3 cycles after the final transition.
- `frame_valid` and `bcd_err` are single-cycle pulses and are never high together.
- A timeout in the same cycle as an edge: the edge wins (counter clears, interval classified as long).
- Reset mid-frame discards all partial state; the next frame needs a full 80 bits.

## Configuration
- Macro `LTC_BCD_CHECK_EN`.
- **Defined:** a sync-aligned frame is rejected if any of the following hold:
  - any units digit > 9;
  - seconds tens > 5 or minutes tens > 5;
  - frames tens > 3;
  - hours > 23.
  
  On rejection, `bcd_err` pulses instead of `frame_valid`, outputs hold, and `locked` is unchanged.
- **Undefined:** every aligned frame is accepted and `bcd_err` is tied 0.

## Test plan
Bench parameters: `SHORT_MAX`=6, `TIMEOUT`=16, bit period 8 clk.
- **Reset:** assert `rst_n`=0 mid-stream -> all outputs 0 immediately. After release, a frame already in progress produces no strobe.
- **Consecutive frames:** send frames 01:23:45:12 then 01:23:45:13 -> two `frame_valid` pulses 640 cycles apart. The first gives hours=6'h01, minutes=7'h23, seconds=7'h45, frames=6'h12; then frames=6'h13. `locked`=1 after the first pulse, and each pulse occurs 3 cycles after the last transition.
- **Drop-frame bit:** frame with bit 10 set -> `drop_frame`=1 with the strobe.
- **Mid-frame join:** start the stream at bit 40, then send one full frame -> the first sync produces no strobe. The second sync gives `frame_valid` with correct fields.
- **Stall:** hold `ltc_in` constant for 20 cycles at bit 30 -> `locked` 0, no strobe for that frame. The next complete frame decodes.
- **BCD check:** frame with frames units = 4'hA:
  - with `LTC_BCD_CHECK_EN` -> `bcd_err` pulse, no `frame_valid`, outputs unchanged;
  - without it -> `frame_valid` with frames=6'h1A when tens=1.

Source files
------------

// File: rtl/ltc_decoder.sv
// ltc_decoder: biphase-mark LTC receiver; times line transitions, assembles the 80-bit frame and
// presents the BCD time fields on sync. Build macro LTC_BCD_CHECK_EN enables BCD range rejection.
//
// state    | meaning
// ST_IDLE  | no timing reference; the next edge only restarts the interval counter
// ST_BOUND | at a bit boundary, no half-bit pending
// ST_HALF  | one short interval seen, waiting for the second half of a 1 bit
module ltc_decoder #(
   parameter int SHORT_MAX = 8437,
   parameter int TIMEOUT   = 22500,
   parameter int CNT_W     = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ltc_in,
   output logic [5:0] hours,
   output logic [6:0] minutes,
   output logic [6:0] seconds,
   output logic [5:0] frames,
   output logic       drop_frame,
   output logic       frame_valid,
   output logic       locked,
   output logic       bcd_err
);

   localparam logic [15:0]      SYNC_WORD = 16'hBFFC;
   localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(SHORT_MAX);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TMO_SAT   = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_BOUND, ST_HALF} state_t;

   state_t           state, state_d;
   logic             s1, s2, s3, edge_det;
   logic [CNT_W-1:0] cnt;
   logic             short_iv, tmo;
   logic             emit, emit_bit, phase_err;
   logic [79:1]      sr;
   logic [79:0]      sr_d;
   logic [6:0]       bit_cnt, bit_cnt_inc;
   logic             sync_hit, bcd_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= ltc_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_det = s2 ^ s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (edge_det)
         cnt <= '0;
      else if (cnt != TMO_SAT)
         cnt <= cnt + 1'b1;
   end

   // cnt holds interval-1 when the closing edge is seen
   assign short_iv = (cnt < SHORT_LIM);
   assign tmo      = !edge_det && (cnt == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d   = state;
      emit      = 1'b0;
      emit_bit  = 1'b0;
      phase_err = 1'b0;
      case (state)
         ST_IDLE: begin
            if (edge_det)
               state_d = ST_BOUND;
         end
         ST_BOUND: begin
            if (edge_det) begin
               if (short_iv)
                  state_d = ST_HALF;
               else
                  emit = 1'b1;
            end else if (tmo) begin
               state_d = ST_IDLE;
            end
         end
         ST_HALF: begin
            if (edge_det) begin
               state_d = ST_BOUND;
               if (short_iv) begin
                  emit     = 1'b1;
                  emit_bit = 1'b1;
               end else begin
                  phase_err = 1'b1;
               end
            end else if (tmo) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // sr_d[0] is frame bit 0 only at the moment of sync, so it never needs storing
   assign sr_d        = {emit_bit, sr};
   assign bit_cnt_inc = (bit_cnt == 7'd81) ? 7'd81 : bit_cnt + 7'd1;
   assign sync_hit    = (sr_d[79:64] == SYNC_WORD);

`ifdef LTC_BCD_CHECK_EN
   // frames tens is two bits wide and can never exceed 3
   always_comb begin
      bcd_ok = 1'b1;
      if (sr_d[3:0] > 4'd9 || sr_d[19:16] > 4'd9 || sr_d[35:32] > 4'd9 || sr_d[51:48] > 4'd9)
         bcd_ok = 1'b0;
      if (sr_d[26:24] > 3'd5 || sr_d[42:40] > 3'd5)
         bcd_ok = 1'b0;
      if (sr_d[57:56] == 2'd3 || (sr_d[57:56] == 2'd2 && sr_d[51:48] > 4'd3))
         bcd_ok = 1'b0;
   end
`else
   assign bcd_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr          <= '0;
         bit_cnt     <= '0;
         locked      <= 1'b0;
         frame_valid <= 1'b0;
         bcd_err     <= 1'b0;
         hours       <= '0;
         minutes     <= '0;
         seconds     <= '0;
         frames      <= '0;
         drop_frame  <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         bcd_err     <= 1'b0;
         if (tmo || phase_err) begin
            locked  <= 1'b0;
            bit_cnt <= '0;
         end else if (emit) begin
            sr <= sr_d[79:1];
            if (sync_hit) begin
               bit_cnt <= '0;
               if (bit_cnt_inc == 7'd80) begin
                  if (bcd_ok) begin
                     frames      <= {sr_d[9:8], sr_d[3:0]};
                     drop_frame  <= sr_d[10];
                     seconds     <= {sr_d[26:24], sr_d[19:16]};
                     minutes     <= {sr_d[42:40], sr_d[35:32]};
                     hours       <= {sr_d[57:56], sr_d[51:48]};
                     frame_valid <= 1'b1;
                     locked      <= 1'b1;
                  end else begin
                     bcd_err <= 1'b1;
                  end
               end else begin
                  locked <= 1'b0;
               end
            end else begin
               bit_cnt <= bit_cnt_inc;
               if (bit_cnt_inc == 7'd81)
                  locked <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ltc_decoder.sv
// tb_ltc_decoder: directed biphase-mark frames into ltc_decoder (half-bit 4 clk, bit 8 clk),
// checking fields, strobe latency, lock behaviour, stalls, resets and the optional BCD check.
module tb_ltc_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ltc_in = 1'b0;
   logic [5:0] hours;
   logic [6:0] minutes;
   logic [6:0] seconds;
   logic [5:0] frames;
   logic       drop_frame;
   logic       frame_valid;
   logic       locked;
   logic       bcd_err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int tog_cyc = 0;
   int fv_cnt = 0;
   int fv_cyc = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   ltc_decoder #(.SHORT_MAX(6), .TIMEOUT(16), .CNT_W(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ltc_in(ltc_in),
      .hours(hours),
      .minutes(minutes),
      .seconds(seconds),
      .frames(frames),
      .drop_frame(drop_frame),
      .frame_valid(frame_valid),
      .locked(locked),
      .bcd_err(bcd_err)
   );

   initial forever #5 clk = ~clk;

   // cycle count and strobe recorder, sampled 1 time unit after each rising edge
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (frame_valid) begin
         fv_cnt++;
         fv_cyc = cyc;
      end
      if (bcd_err)
         err_cnt++;
      if (frame_valid && bcd_err)
         both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic toggle();
      ltc_in  = ~ltc_in;
      tog_cyc = cyc;
   endtask

   task automatic send_bit(input logic b);
      toggle();
      wait_clk(4);
      if (b)
         toggle();
      wait_clk(4);
   endtask

   task automatic send_frame(input logic [79:0] fr, input int first, input int last);
      for (int i = first; i <= last; i++)
         send_bit(fr[i]);
   endtask

   // closing transition of a frame (start of the next bit); waits until the strobe is due
   task automatic end_frame(output int t);
      toggle();
      t = tog_cyc;
      wait_clk(3);
   endtask

   // completes a bit whose starting transition came from end_frame
   task automatic finish_bit(input logic b);
      wait_clk(1);
      if (b)
         toggle();
      wait_clk(4);
   endtask

   function automatic logic [79:0] make_frame(input logic [5:0] h, input logic [6:0] m,
                                              input logic [6:0] s, input logic [5:0] f,
                                              input logic df);
      logic [79:0] fr;
      fr          = '0;
      fr[3:0]     = f[3:0];
      fr[9:8]     = f[5:4];
      fr[10]      = df;
      fr[19:16]   = s[3:0];
      fr[26:24]   = s[6:4];
      fr[31:28]   = 4'hF;
      fr[35:32]   = m[3:0];
      fr[42:40]   = m[6:4];
      fr[51:48]   = h[3:0];
      fr[57:56]   = h[5:4];
      fr[79:64]   = 16'hBFFC;
      return fr;
   endfunction

   initial begin
      logic [79:0] f1, f2, f3, f4, f5, f6, f7;
      int t, fv_first, fv_before;

      f1 = make_frame(6'h01, 7'h23, 7'h45, 6'h12, 1'b0);
      f2 = make_frame(6'h01, 7'h23, 7'h45, 6'h13, 1'b0);
      f3 = make_frame(6'h02, 7'h00, 7'h00, 6'h00, 1'b1);
      f4 = make_frame(6'h12, 7'h34, 7'h56, 6'h07, 1'b0);
      f5 = make_frame(6'h23, 7'h59, 7'h59, 6'h29, 1'b0);
      f6 = make_frame(6'h10, 7'h20, 7'h30, 6'h15, 1'b0);
      f7 = make_frame(6'h05, 7'h06, 7'h07, 6'h1A, 1'b0);

      wait_clk(2);
      check("rst_fields", {hours, minutes, seconds, frames, drop_frame}, 32'h0);
      check("rst_valid", frame_valid, 1'b0);
      check("rst_locked", locked, 1'b0);
      check("rst_bcd_err", bcd_err, 1'b0);
      rst_n = 1'b1;
      wait_clk(20);

      // two back-to-back frames
      send_frame(f1, 0, 79);
      end_frame(t);
      check("f1_count", fv_cnt, 1);
      check("f1_latency", fv_cyc - t, 3);
      check("f1_hours", hours, 6'h01);
      check("f1_minutes", minutes, 7'h23);
      check("f1_seconds", seconds, 7'h45);
      check("f1_frames", frames, 6'h12);
      check("f1_drop", drop_frame, 1'b0);
      check("f1_locked", locked, 1'b1);
      fv_first = fv_cyc;
      finish_bit(f2[0]);
      send_frame(f2, 1, 79);
      end_frame(t);
      check("f2_count", fv_cnt, 2);
      check("f2_latency", fv_cyc - t, 3);
      check("f2_spacing", fv_cyc - fv_first, 640);
      check("f2_frames", frames, 6'h13);
      check("f2_locked", locked, 1'b1);
      wait_clk(1);
      check("pulse_width", frame_valid, 1'b0);
      wait_clk(30);
      check("timeout_unlock", locked, 1'b0);

      // drop-frame flag
      send_frame(f3, 0, 79);
      end_frame(t);
      check("df_count", fv_cnt, 3);
      check("df_flag", drop_frame, 1'b1);
      check("df_hours", hours, 6'h02);
      wait_clk(30);

      // join the stream at bit 40
      send_frame(f4, 40, 79);
      end_frame(t);
      check("join_no_strobe", fv_cnt, 3);
      check("join_unlocked", locked, 1'b0);
      finish_bit(f4[0]);
      send_frame(f4, 1, 79);
      end_frame(t);
      check("join_count", fv_cnt, 4);
      check("join_fields", {hours, minutes, seconds, frames}, {6'h12, 7'h34, 7'h56, 6'h07});
      check("join_drop", drop_frame, 1'b0);
      check("join_locked", locked, 1'b1);

      // line stalls at bit 30
      finish_bit(f5[0]);
      send_frame(f5, 1, 29);
      check("stall_locked_before", locked, 1'b1);
      wait_clk(20);
      check("stall_unlock", locked, 1'b0);
      send_frame(f5, 30, 79);
      end_frame(t);
      check("stall_no_strobe", fv_cnt, 4);
      finish_bit(f6[0]);
      send_frame(f6, 1, 79);
      end_frame(t);
      check("stall_count", fv_cnt, 5);
      check("stall_fields", {hours, minutes, seconds, frames}, {6'h10, 7'h20, 7'h30, 6'h15});
      check("stall_locked_after", locked, 1'b1);

      // frames units digit out of range
      finish_bit(f7[0]);
      send_frame(f7, 1, 79);
      end_frame(t);
`ifdef LTC_BCD_CHECK_EN
      check("bcd_valid_count", fv_cnt, 5);
      check("bcd_err_count", err_cnt, 1);
      check("bcd_hold", {hours, minutes, seconds, frames}, {6'h10, 7'h20, 7'h30, 6'h15});
      check("bcd_locked", locked, 1'b1);
`else
      check("bcd_valid_count", fv_cnt, 6);
      check("bcd_err_count", err_cnt, 0);
      check("bcd_fields", {hours, minutes, seconds, frames}, {6'h05, 7'h06, 7'h07, 6'h1A});
      check("bcd_locked", locked, 1'b1);
`endif

      // asynchronous reset in the middle of a frame
      fv_before = fv_cnt;
      finish_bit(f1[0]);
      send_frame(f1, 1, 39);
      rst_n = 1'b0;
      #1;
      check("midrst_fields", {hours, minutes, seconds, frames, drop_frame}, 32'h0);
      check("midrst_locked", locked, 1'b0);
      check("midrst_valid", frame_valid, 1'b0);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(25);
      send_frame(f1, 40, 79);
      end_frame(t);
      check("midrst_no_strobe", fv_cnt, fv_before);
      finish_bit(f1[0]);
      send_frame(f1, 1, 79);
      end_frame(t);
      check("midrst_count", fv_cnt, fv_before + 1);
      check("midrst_latency", fv_cyc - t, 3);
      check("midrst_fields_after", {hours, minutes, seconds, frames}, {6'h01, 7'h23, 7'h45, 6'h12});

      wait_clk(4);
      check("never_both", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
